// File: rtl/intr_ctrl_pkg.sv
// Shared types and constants for the interrupt controller: FSM encoding,
// config register map and the intId width helper.
package intr_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_ENABLE  = 2'd0;
    localparam logic [1:0] ADDR_EDGE    = 2'd1;
    localparam logic [1:0] ADDR_PENDING = 2'd2;
    localparam logic [1:0] ADDR_CTRL    = 2'd3;

    localparam int CTRL_GIE_BIT = 0;

    // A single source still needs a one-bit id.
    function automatic int id_width(input int num_src);
        return (num_src > 1) ? $clog2(num_src) : 1;
    endfunction

endpackage

// File: rtl/intr_sync.sv
// One-bit synchroniser for an asynchronous interrupt line, with a rising-edge
// detector on the synchronised output.
module intr_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s_prev_q;
    logic                   s_prev_d;

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], d};
        s_prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            s_prev_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            s_prev_q <= s_prev_d;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_prev_q;

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller for the multicycle core: synchronises sources, latches
// pending events, picks the lowest-index eligible one and tracks its service.
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int NUM_SRC     = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ID_W        = id_width(NUM_SRC)
) (
    input  logic               clk,
    input  logic               RST_n,
    input  logic [NUM_SRC-1:0] src,
    input  logic               cfgWrite,
    input  logic [1:0]         cfgAddr,
    input  logic [31:0]        cfgData,
    output logic [31:0]        cfgRdata,
    input  logic               intTaken,
    input  logic               intRet,
    output logic               INTR,
    output logic [ID_W-1:0]    intId,
    output logic               intActive
);

    logic [NUM_SRC-1:0] s_vec;
    logic [NUM_SRC-1:0] rise_vec;

    logic [NUM_SRC-1:0] enable_q,  enable_d;
    logic [NUM_SRC-1:0] edge_q,    edge_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic               gie_q,     gie_d;
    state_t             state_q,   state_d;
    logic [ID_W-1:0]    int_id_q,  int_id_d;

    logic [NUM_SRC-1:0] eligible;
    logic [ID_W-1:0]    winner_id;
    logic               taken;
    logic               wr_enable;
    logic               wr_edge;
    logic               wr_pending;
    logic               wr_ctrl;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_sync
            intr_sync #(
                .SYNC_STAGES(SYNC_STAGES)
            ) u_sync (
                .clk  (clk),
                .rst_n(RST_n),
                .d    (src[gi]),
                .s    (s_vec[gi]),
                .rise (rise_vec[gi])
            );
        end
    endgenerate

    assign wr_enable  = cfgWrite && (cfgAddr == ADDR_ENABLE);
    assign wr_edge    = cfgWrite && (cfgAddr == ADDR_EDGE);
    assign wr_pending = cfgWrite && (cfgAddr == ADDR_PENDING);
    assign wr_ctrl    = cfgWrite && (cfgAddr == ADDR_CTRL);

    assign eligible = pending_q & enable_q & {NUM_SRC{gie_q}};
    assign taken    = (state_q == REQ) && intTaken;

    // Scanning from the top down lets the lowest set index overwrite the rest.
    always_comb begin
        winner_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        enable_d = enable_q;
        edge_d   = edge_q;
        gie_d    = gie_q;
        if (wr_enable) begin
            enable_d = cfgData[NUM_SRC-1:0];
        end
        if (wr_edge) begin
            edge_d = cfgData[NUM_SRC-1:0];
        end
        if (wr_ctrl) begin
            gie_d = cfgData[CTRL_GIE_BIT];
        end
    end

    // Edge bits: set beats clear so an event arriving with its own clear survives.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (edge_q[i]) begin
                pending_d[i] = rise_vec[i] |
                               (pending_q[i] &
                                ~((wr_pending && cfgData[i]) ||
                                  (taken && (int_id_q == ID_W'(i)))));
            end else begin
                pending_d[i] = s_vec[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        int_id_d = int_id_q;
        case (state_q)
            IDLE: begin
                if (eligible != '0) begin
                    int_id_d = winner_id;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (intTaken) begin
                    state_d = SERVICE;
                end else if (!eligible[int_id_q]) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (intRet) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            enable_q  <= '0;
            edge_q    <= '0;
            pending_q <= '0;
            gie_q     <= 1'b0;
            state_q   <= IDLE;
            int_id_q  <= '0;
        end else begin
            enable_q  <= enable_d;
            edge_q    <= edge_d;
            pending_q <= pending_d;
            gie_q     <= gie_d;
            state_q   <= state_d;
            int_id_q  <= int_id_d;
        end
    end

    always_comb begin
        cfgRdata = '0;
        case (cfgAddr)
            ADDR_ENABLE:  cfgRdata = 32'(enable_q);
            ADDR_EDGE:    cfgRdata = 32'(edge_q);
            ADDR_PENDING: cfgRdata = 32'(pending_q);
            ADDR_CTRL:    cfgRdata[CTRL_GIE_BIT] = gie_q;
            default:      cfgRdata = '0;
        endcase
    end

    assign INTR      = (state_q == REQ);
    assign intActive = (state_q == SERVICE);
    assign intId     = int_id_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: config register vectors from a table,
// then hand-written interrupt sequences with an intId scoreboard.
module tb_intr_ctrl;
    import intr_ctrl_pkg::*;

    localparam int NUM_SRC     = 8;
    localparam int SYNC_STAGES = 2;
    localparam int ID_W        = 3;

    logic               clk = 1'b0;
    logic               RST_n;
    logic [NUM_SRC-1:0] src;
    logic               cfgWrite;
    logic [1:0]         cfgAddr;
    logic [31:0]        cfgData;
    logic [31:0]        cfgRdata;
    logic               intTaken;
    logic               intRet;
    logic               INTR;
    logic [ID_W-1:0]    intId;
    logic               intActive;

    int errors = 0;
    int checks = 0;
    logic [ID_W-1:0] exp_q[$];

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] expect_rd;
    } cfg_vec_t;

    cfg_vec_t vecs[7];

    intr_ctrl #(
        .NUM_SRC    (NUM_SRC),
        .SYNC_STAGES(SYNC_STAGES),
        .ID_W       (ID_W)
    ) dut (
        .clk      (clk),
        .RST_n    (RST_n),
        .src      (src),
        .cfgWrite (cfgWrite),
        .cfgAddr  (cfgAddr),
        .cfgData  (cfgData),
        .cfgRdata (cfgRdata),
        .intTaken (intTaken),
        .intRet   (intRet),
        .INTR     (INTR),
        .intId    (intId),
        .intActive(intActive)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("check %s = 0x%0h ok", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [31:0] data);
        cfgWrite = 1'b1;
        cfgAddr  = addr;
        cfgData  = data;
        tick();
        cfgWrite = 1'b0;
        cfgData  = '0;
        $display("cfg write addr=%0d data=0x%0h", addr, data);
    endtask

    task automatic cfg_read(input logic [1:0] addr, output logic [31:0] data);
        cfgAddr = addr;
        #1;
        data = cfgRdata;
    endtask

    task automatic check_reg(input string name, input logic [1:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        cfg_read(addr, rd);
        check(name, rd, exp);
    endtask

    // Waits for INTR, then pops the expected intId from the scoreboard.
    task automatic wait_req(input string name, input int max_cycles, output int n);
        n = 0;
        while (!INTR && n < max_cycles) begin
            tick();
            n++;
        end
        check({name, " INTR"}, 32'(INTR), 32'd1);
        if (INTR) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s intId: got %0d, expected nothing queued", name, intId);
            end else begin
                check({name, " intId"}, 32'(intId), 32'(exp_q.pop_front()));
            end
        end
    endtask

    task automatic pulse_taken();
        intTaken = 1'b1;
        tick();
        intTaken = 1'b0;
        $display("intTaken pulse");
    endtask

    task automatic pulse_ret();
        intRet = 1'b1;
        tick();
        intRet = 1'b0;
        $display("intRet pulse");
    endtask

    initial begin
        int n;
        RST_n    = 1'b0;
        src      = '0;
        cfgWrite = 1'b0;
        cfgAddr  = '0;
        cfgData  = '0;
        intTaken = 1'b0;
        intRet   = 1'b0;

        vecs[0] = '{ADDR_ENABLE,  32'h0000_00A5, 32'h0000_00A5};
        vecs[1] = '{ADDR_ENABLE,  32'hFFFF_FF5A, 32'h0000_005A};
        vecs[2] = '{ADDR_EDGE,    32'h0000_003C, 32'h0000_003C};
        vecs[3] = '{ADDR_EDGE,    32'h0000_0100, 32'h0000_0000};
        vecs[4] = '{ADDR_CTRL,    32'hFFFF_FFFF, 32'h0000_0001};
        vecs[5] = '{ADDR_CTRL,    32'hFFFF_FFFE, 32'h0000_0000};
        vecs[6] = '{ADDR_PENDING, 32'h0000_00FF, 32'h0000_0000};

        // Reset state
        tick();
        tick();
        check("rst INTR", 32'(INTR), 32'd0);
        check("rst intActive", 32'(intActive), 32'd0);
        check("rst intId", 32'(intId), 32'd0);
        for (int a = 0; a < 4; a++) begin
            check_reg($sformatf("rst reg%0d", a), 2'(a), 32'd0);
        end
        RST_n = 1'b1;
        tick();

        // Config register vectors (gie ends at 0, no sources active)
        for (int v = 0; v < 7; v++) begin
            cfg_write(vecs[v].addr, vecs[v].wdata);
            check_reg($sformatf("vec%0d readback", v), vecs[v].addr, vecs[v].expect_rd);
        end

        // 1) single edge source, latency and service handshake
        cfg_write(ADDR_ENABLE, 32'h04);
        cfg_write(ADDR_EDGE, 32'h04);
        cfg_write(ADDR_CTRL, 32'h01);
        src[2] = 1'b1;
        exp_q.push_back(3'd2);
        tick();
        src[2] = 1'b0;
        wait_req("t1", 10, n);
        check("t1 latency", 32'(n + 1), 32'(SYNC_STAGES + 2));
        pulse_taken();
        check("t1 INTR after take", 32'(INTR), 32'd0);
        check("t1 intActive", 32'(intActive), 32'd1);
        check_reg("t1 PENDING", ADDR_PENDING, 32'h0);
        pulse_ret();
        tick();
        check("t1 intActive after ret", 32'(intActive), 32'd0);
        check("t1 INTR after ret", 32'(INTR), 32'd0);

        // 2) simultaneous edges, fixed priority then second request
        cfg_write(ADDR_ENABLE, 32'hFF);
        cfg_write(ADDR_EDGE, 32'hFF);
        src = 8'h22;
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd5);
        tick();
        src = 8'h00;
        wait_req("t2 first", 10, n);
        pulse_taken();
        check_reg("t2 PENDING in service", ADDR_PENDING, 32'h20);
        check("t2 INTR in service", 32'(INTR), 32'd0);
        pulse_ret();
        wait_req("t2 second", 3, n);
        pulse_taken();
        check_reg("t2 PENDING cleared", ADDR_PENDING, 32'h00);
        pulse_ret();

        // 3) level source: re-request after ret, withdraw on drop
        cfg_write(ADDR_EDGE, 32'h00);
        src[3] = 1'b1;
        exp_q.push_back(3'd3);
        wait_req("t3 first", 10, n);
        pulse_taken();
        check("t3 intActive", 32'(intActive), 32'd1);
        pulse_ret();
        exp_q.push_back(3'd3);
        wait_req("t3 rerequest", 1, n);
        src[3] = 1'b0;
        n = 0;
        while (INTR && n < SYNC_STAGES + 2) begin
            tick();
            n++;
        end
        check("t3 withdrawn INTR", 32'(INTR), 32'd0);
        check("t3 withdrawn intActive", 32'(intActive), 32'd0);

        // 4) ENABLE cleared in the same cycle as intTaken
        src[3] = 1'b1;
        exp_q.push_back(3'd3);
        wait_req("t4", 10, n);
        intTaken = 1'b1;
        cfg_write(ADDR_ENABLE, 32'h00);
        intTaken = 1'b0;
        check("t4 intActive", 32'(intActive), 32'd1);
        check("t4 INTR", 32'(INTR), 32'd0);
        check_reg("t4 ENABLE", ADDR_ENABLE, 32'h00);
        src[3] = 1'b0;
        pulse_ret();
        tick();
        check("t4 idle INTR", 32'(INTR), 32'd0);
        check("t4 idle intActive", 32'(intActive), 32'd0);

        // 5) write-1-clear coinciding with rise[6]: set wins
        cfg_write(ADDR_EDGE, 32'h40);
        tick();
        tick();
        tick();
        check_reg("t5 PENDING before", ADDR_PENDING, 32'h00);
        src[6] = 1'b1;
        tick();
        tick();
        cfg_write(ADDR_PENDING, 32'h40);
        check_reg("t5 PENDING set wins", ADDR_PENDING, 32'h40);
        src[6] = 1'b0;
        cfg_write(ADDR_PENDING, 32'h40);
        check_reg("t5 PENDING cleared", ADDR_PENDING, 32'h00);

        // 6) asynchronous reset while in service
        cfg_write(ADDR_ENABLE, 32'hFF);
        cfg_write(ADDR_EDGE, 32'hFF);
        src[4] = 1'b1;
        exp_q.push_back(3'd4);
        tick();
        src[4] = 1'b0;
        wait_req("t6", 10, n);
        pulse_taken();
        check("t6 intActive before reset", 32'(intActive), 32'd1);
        RST_n = 1'b0;
        #1;
        check("t6 INTR", 32'(INTR), 32'd0);
        check("t6 intActive", 32'(intActive), 32'd0);
        check("t6 intId", 32'(intId), 32'd0);
        for (int a = 0; a < 4; a++) begin
            check_reg($sformatf("t6 reg%0d", a), 2'(a), 32'd0);
        end
        tick();
        RST_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
